// File: rtl/param_tick_gen.sv
// param_tick_gen: programmable count-enable pulse generator.
// Emits one-cycle ticks every div_in+1 cycles, either continuously or as a
// burst of burst_in+1 ticks. All outputs are registered.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset, dominates all inputs
//   start_in  - start request, honoured only while idle
//   stop_in   - abort request, honoured only while running
//   mode_in   - 0 = continuous, 1 = burst (latched at start)
//   div_in    - tick period minus one (latched at start)
//   burst_in  - burst tick count minus one (latched at start)
//   tick_out  - one-cycle enable pulse for the downstream counter
//   busy_out  - high while running
//   done_out  - one-cycle pulse coincident with the final burst tick
module param_tick_gen #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned BURST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic                   stop_in,
  input  logic                   mode_in,
  input  logic [DIV_WIDTH-1:0]   div_in,
  input  logic [BURST_WIDTH-1:0] burst_in,
  output logic                   tick_out,
  output logic                   busy_out,
  output logic                   done_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
  logic [BURST_WIDTH-1:0] burst_lat_q, burst_lat_d;
  logic                   mode_lat_q, mode_lat_d;
  logic [DIV_WIDTH-1:0]   pc_q, pc_d;
  logic [BURST_WIDTH-1:0] tc_q, tc_d;
  logic                   tick_q, tick_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // State register and all flops; reset clears control and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_lat_q   <= '0;
      burst_lat_q <= '0;
      mode_lat_q  <= 1'b0;
      pc_q        <= '0;
      tc_q        <= '0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_lat_q   <= div_lat_d;
      burst_lat_q <= burst_lat_d;
      mode_lat_q  <= mode_lat_d;
      pc_q        <= pc_d;
      tc_q        <= tc_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    div_lat_d   = div_lat_q;
    burst_lat_d = burst_lat_q;
    mode_lat_d  = mode_lat_q;
    pc_d        = pc_q;
    tc_d        = tc_q;
    tick_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A start colliding with a stop is treated as no request.
        if (start_in && !stop_in) begin
          div_lat_d   = div_in;
          burst_lat_d = burst_in;
          mode_lat_d  = mode_in;
          pc_d        = '0;
          tc_d        = '0;
          busy_d      = 1'b1;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop_in) begin
          // Abort wins over a tick due on the same edge.
          pc_d    = '0;
          tc_d    = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (pc_q != div_lat_q) begin
          pc_d = pc_q + DIV_WIDTH'(1);
        end else begin
          pc_d   = '0;
          tick_d = 1'b1;
          if (mode_lat_q) begin
            if (tc_q != burst_lat_q) begin
              tc_d = tc_q + BURST_WIDTH'(1);
            end else begin
              tc_d    = '0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            tc_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tick_out = tick_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_param_tick_gen.sv
// Scoreboard bench for param_tick_gen. The driver applies one input vector
// per edge and pushes the outputs the reference model predicts for that
// edge; the monitor pops one prediction after each edge and compares.
module tb_param_tick_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 4;

  logic          clk;
  logic          rst;
  logic          start_in;
  logic          stop_in;
  logic          mode_in;
  logic [DW-1:0] div_in;
  logic [BW-1:0] burst_in;
  logic          tick_out;
  logic          busy_out;
  logic          done_out;

  param_tick_gen #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_in (start_in),
    .stop_in  (stop_in),
    .mode_in  (mode_in),
    .div_in   (div_in),
    .burst_in (burst_in),
    .tick_out (tick_out),
    .busy_out (busy_out),
    .done_out (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {tick, busy, done} after each edge, in edge order.
  logic [2:0] exp_q[$];
  int n_vec  = 0;
  int n_bad  = 0;

  // Reference model: a run is described by its start edge, period and burst
  // length; outputs follow from the elapsed edge count by plain arithmetic.
  int m_edge  = 0;
  bit m_run   = 0;
  int m_start = 0;
  int m_per   = 1;
  int m_ticks = 1;
  bit m_burst = 0;

  task automatic drive(input logic r, input logic st, input logic sp,
                       input logic md, input int dv, input int bs);
    logic [2:0] e;
    int n;
    rst      = r;
    start_in = st;
    stop_in  = sp;
    mode_in  = md;
    div_in   = DW'(dv);
    burst_in = BW'(bs);
    m_edge++;
    e = 3'b000;
    if (r) begin
      m_run = 0;
    end else if (!m_run) begin
      if (st && !sp) begin
        m_run   = 1;
        m_start = m_edge;
        m_per   = dv + 1;
        m_ticks = bs + 1;
        m_burst = md;
        e = 3'b010;
      end
    end else if (sp) begin
      m_run = 0;
    end else begin
      n = m_edge - m_start;
      e[2] = (n % m_per) == 0;
      e[1] = 1'b1;
      if (m_burst && n == m_ticks * m_per) begin
        e[1] = 1'b0;
        e[0] = 1'b1;
        m_run = 0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one DUT output sample per edge, checked away from the edge.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [2:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tick_out, busy_out, done_out};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL tick/busy/done at edge %0d: actual %b required %b",
                 m_edge - exp_q.size(), a, e);
      end
    end
  end

  initial begin
    int dv;
    int bs;
    // Reset dominance with start held high.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 2, 1);
    idle(2);

    // Continuous, div 3; div_in changes mid-run must be ignored.
    drive(0, 1, 0, 0, 3, 0);
    for (int i = 1; i <= 17; i++) drive(0, 0, 0, 0, (i >= 6) ? 1 : 3, 0);
    drive(0, 0, 1, 0, 3, 0);
    idle(3);

    // Burst div 2, burst 2: ticks after edges 3, 6, 9.
    drive(0, 1, 0, 1, 2, 2);
    idle(12);

    // Minimum burst, then immediate restart on the next edge.
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 0, 1);
    idle(4);

    // Stop on the edge the first tick is due.
    drive(0, 1, 0, 0, 4, 0);
    idle(4);
    drive(0, 0, 1, 0, 4, 0);
    idle(3);
    // Simultaneous start and stop while idle.
    drive(0, 1, 1, 0, 1, 0);
    idle(3);

    // Reset mid-burst, then a fresh full burst.
    drive(0, 1, 0, 1, 1, 7);
    idle(5);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 1, 1, 7);
    idle(20);

    // Extremes: longest period and longest burst.
    drive(0, 1, 0, 1, 255, 1);
    idle(515);
    drive(0, 1, 0, 1, 0, 15);
    idle(20);
    // Start while running is ignored.
    drive(0, 1, 0, 1, 3, 1);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      dv = (($urandom % 8) == 0) ? int'($urandom_range(0, 255)) % 20 : int'($urandom_range(0, 5));
      bs = int'($urandom_range(0, 15));
      drive(($urandom % 200) == 0,
            ($urandom % 3) == 0,
            ($urandom % 25) == 0,
            1'($urandom),
            dv, bs);
    end
    idle(3);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: actual %0d pending required 0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
